// File: rtl/nibble_bus_target.sv
// Target for the nibble-wide multiplexed bus: decodes the two-phase
// address/data transfer and serves nibble reads and writes from a local register file.
module nibble_bus_target #(
    parameter int          DEPTH     = 16,
    parameter int          LOCAL_AW  = 8,
    parameter logic [11:0] BASE_ADDR = 12'h300,
    parameter logic [3:0]  MISS_DATA = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_sel,
    input  logic       bus_rw,
    input  logic [7:0] bus_pins,
    output logic [3:0] bus_data_out,
    output logic       bus_data_oe,
    output logic       bus_err,
    output logic       busy
);
    localparam logic [0:0] PH_A = 1'b0;
    localparam logic [0:0] PH_B = 1'b1;
    localparam int         IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [0:0]            state_q, state_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [DEPTH-1:0][3:0] mem_q, mem_d;
    logic [3:0]            dout_q, dout_d;
    logic                  oe_q, oe_d;
    logic                  err_q, err_d;

    logic [11:0]           addr;
    logic [LOCAL_AW-1:0]   idx;
    logic [IW-1:0]         mem_idx;
    logic                  upper_hit;
    logic                  hit;

    assign addr    = {addr_hi_q, bus_pins[7:4]};
    assign idx     = addr[LOCAL_AW-1:0];
    assign mem_idx = IW'(idx);

    generate
        if (LOCAL_AW < 12) begin : g_upper
            assign upper_hit = (addr[11:LOCAL_AW] == BASE_ADDR[11:LOCAL_AW]);
        end else begin : g_no_upper
            assign upper_hit = 1'b1;
        end
    endgenerate

    // Index range check covers non-power-of-two DEPTH.
    assign hit = upper_hit && (32'(idx) < 32'(DEPTH));

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        mem_d     = mem_q;
        dout_d    = dout_q;
        oe_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            PH_A: begin
                if (bus_sel) begin
                    addr_hi_d = bus_pins;
                    state_d   = PH_B;
                end
            end
            PH_B: begin
                // Dropping bus_sel here aborts the transfer silently.
                state_d = PH_A;
                if (bus_sel) begin
                    if (bus_rw) begin
                        if (hit) mem_d[mem_idx] = bus_pins[3:0];
                        else     err_d = 1'b1;
                    end else if (hit) begin
                        dout_d = mem_q[mem_idx];
                        oe_d   = 1'b1;
                    end else begin
                        dout_d = MISS_DATA;
                        err_d  = 1'b1;
                    end
                end
            end
            default: state_d = PH_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PH_A;
            addr_hi_q <= '0;
            mem_q     <= '0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            mem_q     <= mem_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
        end
    end

    assign bus_data_out = dout_q;
    assign bus_data_oe  = oe_q;
    assign bus_err      = err_q;
    assign busy         = (state_q == PH_B);
endmodule
